// File: rtl/text_tile_buffer.sv
// Dual-plane (character + attribute) text tile memory for the VGA text pipeline.
// Multi-lane strobed bus writes, 1-cycle registered pixel reads, built-in screen fill engine.
module text_tile_buffer #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 30,
    parameter int unsigned CHAR_W   = 7,
    parameter int unsigned ATTR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter logic [7:0]  RST_ATTR = 8'h0F
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               wr_en_i,
    input  logic                               plane_i,
    input  logic [$clog2(COLS*ROWS)-1:0]       w_addr_i,
    input  logic [DATA_W/8-1:0]                w_strb_i,
    input  logic [DATA_W-1:0]                  din_i,
    input  logic [6:0]                         col_r_i,
    input  logic [4:0]                         row_r_i,
    output logic [CHAR_W-1:0]                  char_o,
    output logic [ATTR_W-1:0]                  attr_o,
    input  logic                               clr_req_i,
    input  logic [CHAR_W-1:0]                  clr_char_i,
    input  logic [ATTR_W-1:0]                  clr_attr_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               wr_drop_o
);
    localparam int unsigned NLANES = DATA_W / 8;
    localparam int unsigned NTILES = COLS * ROWS;
    localparam int unsigned ADDR_W = $clog2(NTILES);
    localparam int unsigned TW     = ADDR_W + 1;
    localparam int unsigned DEPTH  = (NTILES + NLANES - 1) / NLANES;
    localparam int unsigned ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BANK_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic {S_IDLE, S_FILL} state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    grp_q, grp_d;
    logic [CHAR_W-1:0]   fill_char_q, fill_char_d;
    logic [ATTR_W-1:0]   fill_attr_q, fill_attr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic [CHAR_W-1:0]   char_q;
    logic [ATTR_W-1:0]   attr_q;

    logic [CHAR_W-1:0]   char_mem [NLANES][DEPTH];
    logic [ATTR_W-1:0]   attr_mem [NLANES][DEPTH];

    logic [NLANES-1:0]   cwe_c, awe_c;
    logic [ROW_W-1:0]    wrow_c [NLANES];
    logic [CHAR_W-1:0]   cwd_c  [NLANES];
    logic [ATTR_W-1:0]   awd_c  [NLANES];
    logic [TW-1:0]       ltile_c [NLANES];

    logic                rd_ok_c;
    logic [31:0]         rd_tile_c;
    logic [BANK_W-1:0]   rd_bank_c;
    logic [ROW_W-1:0]    rd_row_c;

    // Tile index addressed by each bus lane (one extra bit so overflow past NTILES is visible)
    always_comb begin
        for (int unsigned i = 0; i < NLANES; i++) begin
            ltile_c[i] = TW'(w_addr_i) + TW'(i);
        end
    end

    // Per-bank write port: the fill engine owns all banks while active, otherwise bus lanes map onto banks
    always_comb begin
        cwe_c = '0;
        awe_c = '0;
        for (int unsigned b = 0; b < NLANES; b++) begin
            wrow_c[b] = '0;
            cwd_c[b]  = '0;
            awd_c[b]  = '0;
        end
        if (state_q == S_FILL) begin
            for (int unsigned b = 0; b < NLANES; b++) begin
                if (32'(grp_q) * NLANES + b < NTILES) begin
                    cwe_c[b]  = 1'b1;
                    awe_c[b]  = 1'b1;
                    wrow_c[b] = grp_q;
                    cwd_c[b]  = fill_char_q;
                    awd_c[b]  = fill_attr_q;
                end
            end
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (w_strb_i[i] && (ltile_c[i] < TW'(NTILES))) begin
                    wrow_c[BANK_W'(ltile_c[i] % TW'(NLANES))] = ROW_W'(ltile_c[i] / TW'(NLANES));
                    if (plane_i) begin
                        awe_c[BANK_W'(ltile_c[i] % TW'(NLANES))] = 1'b1;
                        awd_c[BANK_W'(ltile_c[i] % TW'(NLANES))] = din_i[8*i +: ATTR_W];
                    end else begin
                        cwe_c[BANK_W'(ltile_c[i] % TW'(NLANES))] = 1'b1;
                        cwd_c[BANK_W'(ltile_c[i] % TW'(NLANES))] = din_i[8*i +: CHAR_W];
                    end
                end
            end
        end
    end

    // Storage is deliberately not reset; the fill engine initialises it
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NLANES; b++) begin
            if (cwe_c[b]) char_mem[b][wrow_c[b]] <= cwd_c[b];
            if (awe_c[b]) attr_mem[b][wrow_c[b]] <= awd_c[b];
        end
    end

    always_comb begin
        rd_ok_c   = (32'(col_r_i) < COLS) && (32'(row_r_i) < ROWS);
        rd_tile_c = 32'(row_r_i) * COLS + 32'(col_r_i);
        rd_bank_c = BANK_W'(rd_tile_c % NLANES);
        rd_row_c  = ROW_W'(rd_tile_c / NLANES);
    end

    // Read port sees pre-write contents when a write hits the same tile in the same cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            char_q <= '0;
            attr_q <= '0;
        end else if (rd_ok_c) begin
            char_q <= char_mem[rd_bank_c][rd_row_c];
            attr_q <= attr_mem[rd_bank_c][rd_row_c];
        end else begin
            char_q <= '0;
            attr_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_FILL;
            grp_q       <= '0;
            fill_char_q <= '0;
            fill_attr_q <= ATTR_W'(RST_ATTR);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            fill_char_q <= fill_char_d;
            fill_attr_q <= fill_attr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        fill_char_d = fill_char_q;
        fill_attr_d = fill_attr_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req_i) begin
                    state_d     = S_FILL;
                    grp_d       = '0;
                    fill_char_d = clr_char_i;
                    fill_attr_d = clr_attr_i;
                end
            end
            S_FILL: begin
                drop_d = wr_en_i;
                if (grp_q == ROW_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    grp_d = grp_q + ROW_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_FILL);
    end

    assign char_o    = char_q;
    assign attr_o    = attr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign wr_drop_o = drop_q;

endmodule

// File: tb/tb_text_tile_buffer.sv
// Self-checking bench for text_tile_buffer: directed cases plus random traffic against a tile-array model.
module tb_text_tile_buffer;
    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int NT       = COLS * ROWS;
    localparam int FILL_CYC = 600;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wr_en_i;
    logic        plane_i;
    logic [11:0] w_addr_i;
    logic [3:0]  w_strb_i;
    logic [31:0] din_i;
    logic [6:0]  col_r_i;
    logic [4:0]  row_r_i;
    logic [6:0]  char_o;
    logic [7:0]  attr_o;
    logic        clr_req_i;
    logic [6:0]  clr_char_i;
    logic [7:0]  clr_attr_i;
    logic        busy_o;
    logic        done_o;
    logic        wr_drop_o;

    int m_char [NT];
    int m_attr [NT];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    text_tile_buffer dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .wr_en_i(wr_en_i), .plane_i(plane_i),
        .w_addr_i(w_addr_i), .w_strb_i(w_strb_i), .din_i(din_i),
        .col_r_i(col_r_i), .row_r_i(row_r_i), .char_o(char_o), .attr_o(attr_o),
        .clr_req_i(clr_req_i), .clr_char_i(clr_char_i), .clr_attr_i(clr_attr_i),
        .busy_o(busy_o), .done_o(done_o), .wr_drop_o(wr_drop_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        wr_en_i = 1'b0; plane_i = 1'b0; w_addr_i = '0; w_strb_i = '0; din_i = '0;
        clr_req_i = 1'b0; clr_char_i = '0; clr_attr_i = '0;
    endtask

    function automatic int exp_char(input int col, input int row);
        return (col < COLS && row < ROWS) ? m_char[row*COLS+col] : 0;
    endfunction

    function automatic int exp_attr(input int col, input int row);
        return (col < COLS && row < ROWS) ? m_attr[row*COLS+col] : 0;
    endfunction

    function automatic void model_write(input bit pl, input int addr, input logic [3:0] strb,
                                        input logic [31:0] din);
        for (int i = 0; i < 4; i++) begin
            if (strb[i] && addr + i < NT) begin
                if (pl) m_attr[addr+i] = int'(din[8*i +: 8]);
                else    m_char[addr+i] = int'(din[8*i +: 7]);
            end
        end
    endfunction

    function automatic void model_fill(input int c, input int a);
        for (int t = 0; t < NT; t++) begin
            m_char[t] = c;
            m_attr[t] = a;
        end
    endfunction

    // One idle-state bus cycle with a read; expectations taken from the model before the write lands
    task automatic cycle(input bit wr, input bit pl, input int addr, input logic [3:0] strb,
                         input logic [31:0] din, input int col, input int row, input string tag);
        int ec, ea;
        wr_en_i = wr; plane_i = pl; w_addr_i = 12'(addr); w_strb_i = strb; din_i = din;
        col_r_i = 7'(col); row_r_i = 5'(row);
        ec = exp_char(col, row);
        ea = exp_attr(col, row);
        if (wr) model_write(pl, addr, strb, din);
        tick();
        wr_en_i = 1'b0; w_strb_i = '0;
        check({tag, "_char"}, 32'(char_o), ec);
        check({tag, "_attr"}, 32'(attr_o), ea);
    endtask

    task automatic read_expect(input string tag, input int col, input int row, input int ec, input int ea);
        col_r_i = 7'(col); row_r_i = 5'(row);
        tick();
        check({tag, "_char"}, 32'(char_o), ec);
        check({tag, "_attr"}, 32'(attr_o), ea);
    endtask

    task automatic scan(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cycle(1'b0, 1'b0, 0, 4'b0000, 32'h0, c, r, tag);
    endtask

    task automatic wait_fill(input int start, input string tag);
        int cnt = start;
        while (done_o !== 1'b1 && cnt < 3000) begin
            tick();
            cnt++;
        end
        check({tag, "_len"}, cnt, FILL_CYC);
        check({tag, "_busy_clear"}, 32'(busy_o), 0);
        tick();
        check({tag, "_done_pulse"}, 32'(done_o), 0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr, col, row;
        set_idle();
        col_r_i = '0; row_r_i = '0;
        rstn_i = 1'b0;
        repeat (3) tick();
        check("rst_char", 32'(char_o), 0);
        check("rst_attr", 32'(attr_o), 0);
        check("rst_busy", 32'(busy_o), 1);
        check("rst_done", 32'(done_o), 0);
        check("rst_drop", 32'(wr_drop_o), 0);
        rstn_i = 1'b1;
        wait_fill(0, "rst_fill");
        model_fill(0, 8'h0F);
        scan("t1");

        // Character plane ramp via lane 0 only, random reads alongside
        for (int t = 0; t < NT; t++)
            cycle(1'b1, 1'b0, t, 4'b0001, 32'(t), $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), "t2w");
        read_expect("t2_5_3", 5, 3, 8'h75, 8'h0F);
        read_expect("t2_79_29", 79, 29, 8'h5F, 8'h0F);
        scan("t2");

        cycle(1'b1, 1'b0, 4, 4'b1111, 32'hBBBBBBBB, 0, 0, "t3w1");
        for (int c = 4; c < 8; c++) read_expect("t3_full", c, 0, 8'h3B, 8'h0F);
        cycle(1'b1, 1'b0, 4, 4'b0000, 32'h44444444, 0, 0, "t3w2");
        for (int c = 4; c < 8; c++) read_expect("t3_nostrb", c, 0, 8'h3B, 8'h0F);
        cycle(1'b1, 1'b0, 4, 4'b0101, 32'h11223344, 0, 0, "t3w3");
        read_expect("t3_c4", 4, 0, 8'h44, 8'h0F);
        read_expect("t3_c5", 5, 0, 8'h3B, 8'h0F);
        read_expect("t3_c6", 6, 0, 8'h22, 8'h0F);
        read_expect("t3_c7", 7, 0, 8'h3B, 8'h0F);

        cycle(1'b1, 1'b1, 2396, 4'b1111, 32'hA1A2A3A4, 0, 0, "t4w");
        read_expect("t4_2396", 76, 29, 8'h5C, 8'hA4);
        read_expect("t4_2397", 77, 29, 8'h5D, 8'hA3);
        read_expect("t4_2398", 78, 29, 8'h5E, 8'hA2);
        read_expect("t4_2399", 79, 29, 8'h5F, 8'hA1);
        read_expect("t4_nowrap", 0, 0, 8'h00, 8'h0F);

        // Random traffic, including past-the-end lanes, out-of-range reads and same-tile read/write
        for (int n = 0; n < 3000; n++) begin
            addr = $urandom_range(0, NT + 3);
            if ($urandom_range(0, 3) == 0 && addr < NT) begin
                col = addr % COLS; row = addr / COLS;
            end else begin
                col = $urandom_range(0, 84); row = $urandom_range(0, 31);
            end
            cycle($urandom_range(0, 3) != 0, 1'($urandom), addr, 4'($urandom), $urandom, col, row, "rnd");
        end

        // Clear request together with a write, then a dropped write and ignored re-request mid-fill
        wr_en_i = 1'b1; plane_i = 1'b0; w_addr_i = 12'd10; w_strb_i = 4'b0001; din_i = 32'h7F;
        clr_req_i = 1'b1; clr_char_i = 7'h20; clr_attr_i = 8'h1E;
        tick();
        set_idle();
        check("t5_busy_start", 32'(busy_o), 1);
        repeat (100) tick();
        wr_en_i = 1'b1; w_addr_i = 12'd0; w_strb_i = 4'b1111; din_i = 32'h55555555;
        clr_req_i = 1'b1; clr_char_i = 7'h55; clr_attr_i = 8'h66;
        tick();
        set_idle();
        check("t5_drop", 32'(wr_drop_o), 1);
        check("t5_busy_mid", 32'(busy_o), 1);
        tick();
        check("t5_drop_pulse", 32'(wr_drop_o), 0);
        wait_fill(102, "t5_fill");
        model_fill(8'h20, 8'h1E);
        scan("t5");

        read_expect("t6_col80", 80, 0, 0, 0);
        read_expect("t6_row30", 0, 30, 0, 0);
        read_expect("t6_max", 127, 31, 0, 0);

        // Reset in the middle of a fill restarts the full post-reset fill
        clr_req_i = 1'b1; clr_char_i = 7'h33; clr_attr_i = 8'h44;
        tick();
        set_idle();
        repeat (300) tick();
        rstn_i = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy_o), 1);
        check("t6_rst_char", 32'(char_o), 0);
        check("t6_rst_attr", 32'(attr_o), 0);
        check("t6_rst_done", 32'(done_o), 0);
        tick();
        rstn_i = 1'b1;
        wait_fill(0, "t6_refill");
        model_fill(0, 8'h0F);
        scan("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
